// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM states, pixel width and 2x2 window byte lanes for max pooling
package pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PIX_W = 8;
  localparam int TL = 0;
  localparam int TR = 8;
  localparam int BL = 16;
  localparam int BR = 24;
  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/maxpooling.sv
// maxpooling: registered unsigned max of a packed 2x2 window
module maxpooling import pool_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [4*PIX_W-1:0] in_data,
  output logic [PIX_W-1:0]   out_data
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out_data <= '0;
    else out_data <= max2(max2(in_data[TL+:PIX_W], in_data[TR+:PIX_W]),
                          max2(in_data[BL+:PIX_W], in_data[BR+:PIX_W]));
endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: frame sequencer feeding 2x2/stride-2 windows to maxpooling with a 2-entry output FIFO
module maxpool_ctrl import pool_pkg::*; #(
  parameter int MAX_W     = 64,
  parameter int MAX_H     = 64,
  parameter int OUT_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
  input  logic                         in_valid,
  input  logic [PIX_W-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [PIX_W-1:0]             out_data,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int CW = $clog2(MAX_W+1);
  localparam int HW = $clog2(MAX_H+1);
  localparam int AW = $clog2(MAX_W);
  state_t state, state_n;
  logic [CW-1:0] width_q, col;
  logic [HW-1:0] height_q, row;
  logic [PIX_W-1:0] linebuf [MAX_W];
  logic [PIX_W-1:0] prev_px, dp_out;
  logic [PIX_W-1:0] fifo [2];
  logic [4*PIX_W-1:0] dp_in;
  logic inflight, wr_ptr, rd_ptr, xfer, issue, last_col, last_px, pop, cfg_ok, drained;
  logic [1:0] count;
  assign cfg_ok    = cfg_width >= 2 && cfg_height >= 2;
  assign xfer      = in_valid & in_ready;
  assign issue     = xfer & row[0] & col[0];
  assign last_col  = col == width_q - 1'b1;
  assign last_px   = xfer & last_col & (row == height_q - 1'b1);
  assign pop       = out_valid & out_ready;
  assign drained   = !inflight && (count == 2'd0 || (count == 2'd1 && pop));
  assign in_ready  = state == RUN && ({1'b0, count} + {2'b0, inflight} < 3'(OUT_DEPTH));
  assign out_valid = count != 2'd0;
  assign out_data  = fifo[rd_ptr];
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
  // col is odd on issue, so the top-row pair is the even/odd entries sharing col's upper bits
  assign dp_in = {in_data, prev_px, linebuf[{col[AW-1:1], 1'b1}], linebuf[{col[AW-1:1], 1'b0}]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (cfg_ok ? RUN : DONE) : IDLE;
      RUN:     state_n = last_px ? DRAIN : RUN;
      DRAIN:   state_n = drained ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
      prev_px  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      fifo     <= '{default: '0};
    end else begin
      state    <= state_n;
      inflight <= issue;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (state == IDLE && start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        col      <= '0;
        row      <= '0;
      end
      if (xfer) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
        if (row[0]) prev_px <= in_data;
      end
      if (inflight) begin
        fifo[wr_ptr] <= dp_out;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  always_ff @(posedge clk)
    if (xfer && !row[0]) linebuf[col[AW-1:0]] <= in_data;
  maxpooling u_dp (
    .clk      (clk),
    .reset_n  (~reset),
    .in_data  (dp_in),
    .out_data (dp_out)
  );
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: directed frames with a scoreboard queue checked by an output monitor
module tb_maxpool_ctrl;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [6:0] cfg_width, cfg_height;
  logic [7:0] in_data, out_data;
  logic [7:0] exp_q[$];
  logic [7:0] frame_px [0:63];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, xfer_first = -1, xfer_last = 0;
  maxpool_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0d expected none", out_data);
      end else chk("out_data", out_data, exp_q.pop_front());
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic send_px(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    if (xfer_first < 0) xfer_first = cyc;
    xfer_last = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_px(frame_px[i]);
  endtask
  task automatic start_frame(input int w, input int h);
    cfg_width  = 7'(w);
    cfg_height = 7'(h);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int t = 0;
    int c0 = done_cnt;
    while (done_cnt == c0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1 chk(name, done_cnt - c0, 1);
  endtask
  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_width = 7'd4; cfg_height = 7'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) frame_px[i] = 8'(i);
    push4(5, 7, 13, 15);
    start_frame(4, 4);
    chk("busy_run", busy, 1);
    xfer_first = -1;
    send_range(0, 16);
    chk("in_cycles", xfer_last - xfer_first + 1, 16);
    wait_done("done_4x4");
    chk("done_gap", done_cyc - last_pop_cyc, 1);
    chk("q_empty_4x4", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    for (int i = 0; i < 16; i++) frame_px[i] = 8'hFF;
    frame_px[0] = 8'h00; frame_px[3] = 8'h00; frame_px[9] = 8'h00; frame_px[15] = 8'h00;
    push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start_frame(4, 4);
    send_range(0, 16);
    wait_done("done_ff");
    chk("q_empty_ff", exp_q.size(), 0);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) frame_px[r*5+c] = 8'(c + 10*r);
    exp_q.push_back(8'd11);
    exp_q.push_back(8'd13);
    start_frame(5, 3);
    send_range(0, 7);
    start_frame(2, 2);
    chk("busy_after_stray_start", busy, 1);
    send_range(7, 15);
    wait_done("done_5x3");
    chk("q_empty_5x3", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) frame_px[i] = 8'(i);
    out_ready = 1'b0;
    push4(5, 7, 13, 15);
    start_frame(4, 4);
    send_range(0, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_held_head", out_data, 5);
    chk("stall_nothing_popped", exp_q.size(), 4);
    out_ready = 1'b1;
    send_range(8, 16);
    wait_done("done_stall");
    chk("q_empty_stall", exp_q.size(), 0);
    push4(5, 7, 13, 15);
    start_frame(4, 4);
    send_range(0, 6);
    reset = 1'b1;
    exp_q.delete();
    c0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - c0, 0);
    chk("midrst_idle_busy", busy, 0);
    push4(5, 7, 13, 15);
    start_frame(4, 4);
    send_range(0, 16);
    wait_done("done_after_rst");
    chk("q_empty_after_rst", exp_q.size(), 0);
    start_frame(1, 4);
    wait_done("done_badcfg");
    chk("badcfg_out_valid", out_valid, 0);
    chk("badcfg_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
